div_bus_master: RTL and testbench
=================================

Name: div_bus_master

Overview:
Bus initiator that drives the divider peripheral's CPU-side register interface (cs/rd/wr/addr/data) on behalf of a hardware client.
- On a request it writes dividend (DV) and divisor (DR), pulses START, polls the status register until DONE, then reads the result.
- Sits between a datapath client (e.g. calculator control) and the divider peripheral, replacing software-driven register access.

Parameters:
DATA_W, 16, bus and operand width
DV_ADDR, 5'h04, dividend register address
DR_ADDR, 5'h08, divisor register address
START_ADDR, 5'h0C, start register address (bit0 = START)
RES_ADDR, 5'h10, result register address
STAT_ADDR, 5'h14, status register address (bit0 = DONE)
POLL_MAX, 255, maximum status polls before timeout (>=1)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start a division; sampled only in IDLE
dividend  in  DATA_W  operand, captured on accepted req
divisor  in  DATA_W  operand, captured on accepted req
busy  out  1  high from first bus cycle until the cycle after done
done  out  1  one-cycle completion pulse
quotient  out  DATA_W  result; held until next accepted req
err  out  1  valid with done: timeout (or divide-by-zero, see feature)
cs  out  1  peripheral chip select
rd  out  1  read strobe
wr  out  1  write strobe
addr  out  5  register address
bus_wdata  out  DATA_W  to peripheral d_in
bus_rdata  in  DATA_W  from peripheral d_out

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; state IDLE; operand and poll registers cleared.
  - Any in-flight access is abandoned immediately, with no completion pulse.
- Bus access:
  - Each access is one ACCESS cycle: cs=1, exactly one of wr/rd =1, addr and bus_wdata stable.
  - Each ACCESS cycle is followed by one GAP cycle: cs=wr=rd=0, addr=0, bus_wdata=0.
  - Read data is captured on the rising edge that ends the ACCESS cycle.
- States: IDLE -> WR_DV -> WR_DR -> WR_START1 -> WR_START0 -> POLL -> RD_RES -> FINISH -> IDLE. Each non-IDLE bus state is ACCESS+GAP.
  - WR_DV writes dividend to DV_ADDR.
  - WR_DR writes divisor to DR_ADDR.
  - WR_START1 writes 1 to START_ADDR; WR_START0 writes 0 to START_ADDR.
  - POLL reads STAT_ADDR.
    - bit0=1: go to RD_RES.
    - bit0=0 and poll count < POLL_MAX: repeat POLL.
    - bit0=0 and poll count reaches POLL_MAX: go to FINISH with err=1 and quotient=0; no RES read.
  - RD_RES reads RES_ADDR and latches quotient.
- Timing (req accepted at edge E0, cycle n = nth cycle after E0):
  - Cycle 1: DV access.
  - Polls occupy cycles 9..8+2P, where P = number of polls.
  - RD_RES access in cycle 9+2P.
  - done=1 in GAP cycle 10+2P; quotient/err valid the same cycle.
  - busy high over cycles 1..10+2P.
  - Example: P=1 gives done in cycle 12.
- req:
  - Ignored while busy, with no queuing.
  - req held high re-triggers only after returning to IDLE; the earliest next DV access is the cycle after IDLE.
- err is cleared on the next accepted req; quotient updates only on successful completion or timeout.
- Poll counter width: clog2(POLL_MAX+1); it does not wrap.

Optional Feature:
DIV0_CHECK_EN
- Defined: an accepted req with divisor==0 issues no bus accesses. done pulses in cycle 1 with quotient={DATA_W{1'b1}} and err=1; busy stays 0.
- Undefined: divisor 0 is sent to the peripheral like any other value; the result is whatever the peripheral returns, or a timeout.

Decomposition:
- Package div_bus_pkg: address constants (DV/DR/START/RES/STAT), DONE bit index, FSM state enum, ACCESS/GAP phase encoding.
- Sub-module div_bus_access: single-access sequencer. Given op (rd/wr), address and write data, it drives ACCESS+GAP, returns rdata, and raises an "ack" pulse in the GAP cycle. The top FSM only sequences operations.

Test Plan:
- dividend=900, divisor=5, peripheral DONE on 3rd poll -> addr sequence 04,08,0C(1),0C(0),14,14,14,10; quotient=180, err=0, done in cycle 16, one pulse.
- Peripheral model never sets DONE, POLL_MAX=4 -> exactly 4 reads of 0x14, no read of 0x10; done with err=1, quotient=0.
- req pulsed again during POLL -> ignored; after done, new req 100/10 -> quotient=10, err cleared.
- reset driven low mid-POLL -> cs/rd/wr/busy/done drop asynchronously to 0; after release, no spurious done; next req 7/2 -> quotient=3.
- DIV0_CHECK_EN defined, divisor=0 -> no cs activity, done in cycle 1, quotient=16'hFFFF, err=1. Undefined -> normal bus sequence is issued.
- Protocol check throughout: every cs=1 cycle followed by cs=0; never rd&wr; bus_wdata=0 in GAP cycles.

Source files
------------

// File: rtl/div_bus_pkg.sv
// Shared constants and encodings for the divider bus initiator: register map,
// status bit index, sequencer states and access phases.
package div_bus_pkg;

  localparam logic [4:0] ADDR_DV    = 5'h04;
  localparam logic [4:0] ADDR_DR    = 5'h08;
  localparam logic [4:0] ADDR_START = 5'h0C;
  localparam logic [4:0] ADDR_RES   = 5'h10;
  localparam logic [4:0] ADDR_STAT  = 5'h14;
  localparam int         STAT_DONE_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DV,
    ST_WR_DR,
    ST_WR_START1,
    ST_WR_START0,
    ST_POLL,
    ST_RD_RES,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ACCESS,
    PH_GAP
  } phase_t;

endpackage

// File: rtl/div_bus_access.sv
// Single register access: one ACCESS cycle (cs plus rd or wr) then one all-zero
// GAP cycle. ack pulses in the GAP cycle, where the next access may be started.
module div_bus_access
  import div_bus_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              op_wr,
  input  logic [4:0]        op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [4:0]        addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic [1:0]        phase_dbg
);

  phase_t phase;

  // Read data is sampled by the caller on the edge that ends the ACCESS cycle.
  assign rdata     = bus_rdata;
  assign phase_dbg = phase;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      phase     <= PH_IDLE;
      cs        <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      bus_wdata <= '0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (phase == PH_ACCESS) begin
        phase     <= PH_GAP;
        cs        <= 1'b0;
        rd        <= 1'b0;
        wr        <= 1'b0;
        addr      <= '0;
        bus_wdata <= '0;
        ack       <= 1'b1;
      end else if (start) begin
        phase     <= PH_ACCESS;
        cs        <= 1'b1;
        rd        <= !op_wr;
        wr        <= op_wr;
        addr      <= op_addr;
        bus_wdata <= op_wr ? op_wdata : '0;
      end else begin
        phase <= PH_IDLE;
      end
    end
  end

endmodule

// File: rtl/div_bus_master.sv
// Hardware initiator for the divider peripheral: writes DV/DR, pulses START,
// polls DONE and reads the result. Build option DIV0_CHECK_EN short-circuits divisor==0.
module div_bus_master
  import div_bus_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter logic [4:0] DV_ADDR    = ADDR_DV,
  parameter logic [4:0] DR_ADDR    = ADDR_DR,
  parameter logic [4:0] START_ADDR = ADDR_START,
  parameter logic [4:0] RES_ADDR   = ADDR_RES,
  parameter logic [4:0] STAT_ADDR  = ADDR_STAT,
  parameter int         POLL_MAX   = 255
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic              err,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [4:0]        addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int PW = $clog2(POLL_MAX + 1);

  state_t            state;
  logic [DATA_W-1:0] dr_q;
  logic [PW-1:0]     poll_cnt;
  logic              acc_start, acc_wr, acc_ack;
  logic [4:0]        acc_addr;
  logic [DATA_W-1:0] acc_wdata, acc_rdata;
  logic [1:0]        acc_phase;
  logic              in_access, accept, div0;

`ifdef DIV0_CHECK_EN
  assign div0 = (divisor == '0);
`else
  assign div0 = 1'b0;
`endif

  assign accept    = (state == ST_IDLE) && req;
  assign in_access = (acc_phase == PH_ACCESS);

  // state already names the next operation during a GAP, so the next access
  // is launched from the ack without a bubble cycle.
  always_comb begin
    acc_start = 1'b0;
    acc_wr    = 1'b1;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state)
      ST_IDLE: begin
        acc_start = accept && !div0;
        acc_addr  = DV_ADDR;
        acc_wdata = dividend;
      end
      ST_WR_DR: begin
        acc_start = acc_ack;
        acc_addr  = DR_ADDR;
        acc_wdata = dr_q;
      end
      ST_WR_START1: begin
        acc_start = acc_ack;
        acc_addr  = START_ADDR;
        acc_wdata = DATA_W'(1);
      end
      ST_WR_START0: begin
        acc_start = acc_ack;
        acc_addr  = START_ADDR;
      end
      ST_POLL: begin
        acc_start = acc_ack;
        acc_wr    = 1'b0;
        acc_addr  = STAT_ADDR;
      end
      ST_RD_RES: begin
        acc_start = acc_ack;
        acc_wr    = 1'b0;
        acc_addr  = RES_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      dr_q     <= '0;
      poll_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && div0) begin
            done     <= 1'b1;
            err      <= 1'b1;
            quotient <= '1;
          end else if (accept) begin
            dr_q  <= divisor;
            busy  <= 1'b1;
            err   <= 1'b0;
            state <= ST_WR_DV;
          end
        end
        ST_WR_DV:     if (in_access) state <= ST_WR_DR;
        ST_WR_DR:     if (in_access) state <= ST_WR_START1;
        ST_WR_START1: if (in_access) state <= ST_WR_START0;
        ST_WR_START0: begin
          if (in_access) begin
            poll_cnt <= '0;
            state    <= ST_POLL;
          end
        end
        ST_POLL: begin
          if (in_access) begin
            if (acc_rdata[STAT_DONE_BIT]) begin
              state <= ST_RD_RES;
            end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
              state    <= ST_FINISH;
              done     <= 1'b1;
              err      <= 1'b1;
              quotient <= '0;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        ST_RD_RES: begin
          if (in_access) begin
            quotient <= acc_rdata;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (acc_ack) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  div_bus_access #(.DATA_W(DATA_W)) u_access (
    .CLK       (CLK),
    .reset     (reset),
    .start     (acc_start),
    .op_wr     (acc_wr),
    .op_addr   (acc_addr),
    .op_wdata  (acc_wdata),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .rdata     (acc_rdata),
    .ack       (acc_ack),
    .phase_dbg (acc_phase)
  );

endmodule

// File: tb/tb_div_bus_master.sv
// Bench for div_bus_master: bench-side divider peripheral, a timing model derived
// from the access schedule, a per-cycle compare process and directed transactions.
module tb_div_bus_master;

  localparam int POLL_MAX = 4;

  logic        CLK, reset, req;
  logic [15:0] dividend, divisor, quotient, bus_wdata, bus_rdata;
  logic        busy, done, err, cs, rd, wr;
  logic [4:0]  addr;

  int tests = 0;
  int fails = 0;

  div_bus_master #(.DATA_W(16), .POLL_MAX(POLL_MAX)) dut (
    .CLK(CLK), .reset(reset), .req(req), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .err(err),
    .cs(cs), .rd(rd), .wr(wr), .addr(addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- peripheral model ----------------
  int          per_done_at = 0;  // poll number that sees DONE; 0 = never
  int          per_polls   = 0;
  logic [15:0] per_dv = '0, per_dr = '0;

  always @(posedge CLK) begin
    if (cs && wr && addr == 5'h04) per_dv <= bus_wdata;
    if (cs && wr && addr == 5'h08) per_dr <= bus_wdata;
    if (cs && wr && addr == 5'h0C && bus_wdata[0]) per_polls <= 0;
    if (cs && rd && addr == 5'h14) per_polls <= per_polls + 1;
  end

  always_comb begin
    bus_rdata = '0;
    if (cs && rd && addr == 5'h14)
      bus_rdata = {15'b0, (per_done_at != 0) && (per_polls + 1 >= per_done_at)};
    else if (cs && rd && addr == 5'h10)
      bus_rdata = (per_dr == 0) ? 16'hFFFF : per_dv / per_dr;
  end

  // ---------------- behavioural model ----------------
  // m_n is the cycle number counted from the accepting edge (cycle 1 = first bus cycle).
  bit          m_active = 0, m_div0 = 0, m_succ = 0;
  int          m_n = 0, m_end = 0, m_p = 0;
  logic [15:0] m_dv = '0, m_dr = '0, m_res = '0, m_q = '0;
  logic        m_err = 0;

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_active = 0;
      m_q      = '0;
      m_err    = 0;
    end else if (!m_active && req) begin
      m_active = 1;
      m_n      = 1;
      m_dv     = dividend;
      m_dr     = divisor;
`ifdef DIV0_CHECK_EN
      m_div0 = (divisor == 0);
`else
      m_div0 = 0;
`endif
      if (m_div0) begin
        m_end = 1;
        m_q   = 16'hFFFF;
        m_err = 1;
      end else begin
        m_err  = 0;
        m_succ = (per_done_at >= 1) && (per_done_at <= POLL_MAX);
        m_p    = m_succ ? per_done_at : POLL_MAX;
        m_end  = m_succ ? 10 + 2 * m_p : 8 + 2 * m_p;
        m_res  = !m_succ ? 16'h0 : (divisor == 0) ? 16'hFFFF : dividend / divisor;
      end
    end else if (m_active) begin
      m_n = m_n + 1;
      if (m_n > m_end) m_active = 0;
      else if (m_n == m_end && !m_div0) begin
        m_q   = m_res;
        m_err = !m_succ;
      end
    end
  end

  // ---------------- compare process / monitor ----------------
  logic [4:0]  acc_addr_q[$];
  logic [15:0] acc_wd_q[$];
  int          done_cnt = 0;
  logic        prev_cs  = 0;

  always @(negedge CLK) begin : cmp
    logic       e_busy, e_done, e_cs, e_rd, e_wr;
    logic [4:0] e_addr;
    logic [15:0] e_wd;
    int k;
    if (reset) begin
      e_busy = 0; e_done = 0; e_cs = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      if (m_active && m_div0) begin
        e_done = (m_n == 1);
      end else if (m_active) begin
        e_busy = 1;
        e_done = (m_n == m_end);
        if ((m_n % 2) == 1) begin
          k    = (m_n - 1) / 2;
          e_cs = 1;
          case (k)
            0: begin e_wr = 1; e_addr = 5'h04; e_wd = m_dv; end
            1: begin e_wr = 1; e_addr = 5'h08; e_wd = m_dr; end
            2: begin e_wr = 1; e_addr = 5'h0C; e_wd = 16'd1; end
            3: begin e_wr = 1; e_addr = 5'h0C; e_wd = 16'd0; end
            default: begin e_rd = 1; e_addr = (k < 4 + m_p) ? 5'h14 : 5'h10; end
          endcase
        end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("cs", cs, e_cs);
      chk("rd", rd, e_rd);
      chk("wr", wr, e_wr);
      chk("addr", addr, e_addr);
      chk("bus_wdata", bus_wdata, e_wd);
      chk("quotient", quotient, m_q);
      chk("err", err, m_err);
      chk("cs_followed_by_gap", prev_cs && cs, 0);
      chk("rd_and_wr", rd && wr, 0);
      if (cs) begin
        acc_addr_q.push_back(addr);
        acc_wd_q.push_back(bus_wdata);
      end
      if (done) done_cnt++;
      prev_cs = cs;
    end else begin
      prev_cs = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic run_div(input logic [15:0] dv, input logic [15:0] dr, input int done_at,
                         input int extra_req, output int cyc, output logic [15:0] q,
                         output logic e);
    logic d;
    acc_addr_q.delete();
    acc_wd_q.delete();
    done_cnt = 0;
    cyc = 0; q = '0; e = 0;
    @(negedge CLK);
    #2;
    dividend = dv; divisor = dr; per_done_at = done_at; req = 1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      d = done;
      if (d) begin q = quotient; e = err; end
      #2 req = (c == extra_req);
      if (d) begin cyc = c; break; end
    end
    req = 0;
    if (cyc == 0) chk("done_within_budget", 0, 1);
    repeat (3) @(negedge CLK);
  endtask

  function automatic int count_addr(input logic [4:0] a);
    int n = 0;
    foreach (acc_addr_q[i]) if (acc_addr_q[i] == a) n++;
    return n;
  endfunction

  // ---------------- directed sequence ----------------
  logic [4:0]  exp_q[$];
  int          cyc;
  logic [15:0] q;
  logic        e;

  initial begin
    reset = 0; req = 0; dividend = '0; divisor = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", cs, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_err", err, 0);
    #2 reset = 1;
    repeat (2) @(negedge CLK);

    // 900/5, DONE on the third poll.
    run_div(16'd900, 16'd5, 3, 0, cyc, q, e);
    chk("t1_done_cycle", cyc, 16);
    chk("t1_quotient", q, 180);
    chk("t1_err", e, 0);
    chk("t1_done_pulses", done_cnt, 1);
    exp_q = '{5'h04, 5'h08, 5'h0C, 5'h0C, 5'h14, 5'h14, 5'h14, 5'h10};
    chk("t1_access_count", acc_addr_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < acc_addr_q.size()) chk("t1_addr_seq", acc_addr_q[i], exp_q[i]);
    if (acc_wd_q.size() > 3) begin
      chk("t1_start1_data", acc_wd_q[2], 1);
      chk("t1_start0_data", acc_wd_q[3], 0);
    end

    // DONE never set: timeout after POLL_MAX polls.
    run_div(16'd1234, 16'd7, 0, 0, cyc, q, e);
    chk("t2_done_cycle", cyc, 16);
    chk("t2_quotient", q, 0);
    chk("t2_err", e, 1);
    chk("t2_stat_reads", count_addr(5'h14), 4);
    chk("t2_res_reads", count_addr(5'h10), 0);

    // Extra req during POLL is ignored; err from the timeout is cleared.
    run_div(16'd120, 16'd7, 2, 10, cyc, q, e);
    chk("t3_done_cycle", cyc, 14);
    chk("t3_quotient", q, 17);
    chk("t3_err", e, 0);
    chk("t3_dv_writes", count_addr(5'h04), 1);

    run_div(16'd100, 16'd10, 1, 0, cyc, q, e);
    chk("t4_done_cycle", cyc, 12);
    chk("t4_quotient", q, 10);
    chk("t4_err", e, 0);

    // DONE seen on the very last allowed poll still succeeds.
    run_div(16'hFFFF, 16'd3, POLL_MAX, 0, cyc, q, e);
    chk("t5_done_cycle", cyc, 18);
    chk("t5_quotient", q, 16'h5555);
    chk("t5_err", e, 0);

    // Asynchronous reset in the middle of a POLL access.
    @(negedge CLK);
    #2 dividend = 16'd77; divisor = 16'd3; per_done_at = 0; req = 1;
    @(negedge CLK);
    #2 req = 0;
    repeat (8) @(negedge CLK);
    chk("t6_pre_reset_poll", {cs, rd, addr}, {1'b1, 1'b1, 5'h14});
    #3 reset = 0;
    #1;
    chk("t6_async_cs", cs, 0);
    chk("t6_async_rd", rd, 0);
    chk("t6_async_wr", wr, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_done", done, 0);
    chk("t6_async_addr", addr, 0);
    repeat (2) @(negedge CLK);
    #2 reset = 1;
    done_cnt = 0;
    repeat (20) @(negedge CLK);
    chk("t6_no_spurious_done", done_cnt, 0);
    run_div(16'd7, 16'd2, 1, 0, cyc, q, e);
    chk("t6_done_cycle", cyc, 12);
    chk("t6_quotient", q, 3);

    // Divisor zero.
    run_div(16'd50, 16'd0, 1, 0, cyc, q, e);
`ifdef DIV0_CHECK_EN
    chk("t7_done_cycle", cyc, 1);
    chk("t7_quotient", q, 16'hFFFF);
    chk("t7_err", e, 1);
    chk("t7_bus_accesses", acc_addr_q.size(), 0);
`else
    chk("t7_done_cycle", cyc, 12);
    chk("t7_quotient", q, 16'hFFFF);
    chk("t7_err", e, 0);
    chk("t7_bus_accesses", acc_addr_q.size(), 6);
    chk("t7_dr_write", count_addr(5'h08), 1);
`endif

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
